// File: rtl/i2c_master_engine.sv
// i2c_master_engine: I2C master bit/byte engine driving open-drain SDA/SCL
// (1 = released, 0 = driven low). It takes one bus command per write/ready
// handshake: START, RESTART, WRITE, READ or STOP. Each command is played out
// as a sequence of SCL quarter-periods, and each quarter lasts CLK_DIV clk_in cycles.
// Optional feature: define I2C_CLOCK_STRETCH_EN so that a slave holding SCL low
// pauses any quarter in which the engine releases SCL.
module i2c_master_engine #(
   parameter int CLK_DIV   = 250,
   parameter int CTR_WIDTH = 16
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic       write,
   input  logic [2:0] cmd,
   input  logic [7:0] data_in,
   input  logic       nack,
   input  logic       sda_in,
   input  logic       scl_in,
   output logic       ready_out,
   output logic       sda_out,
   output logic       scl_out,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       ack_out,
   output logic       err_out
);

   localparam logic [2:0] CMD_START   = 3'd1;
   localparam logic [2:0] CMD_WRITE   = 3'd2;
   localparam logic [2:0] CMD_READ    = 3'd3;
   localparam logic [2:0] CMD_STOP    = 3'd4;
   localparam logic [2:0] CMD_RESTART = 3'd5;

   localparam logic [CTR_WIDTH-1:0] Q_LAST = CTR_WIDTH'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      ENG_READY,
      ENG_RUN,
      ENG_DONE,
      ENG_NOBUS
   } eng_state_t;

   eng_state_t           state;
   logic [2:0]           op;
   logic [CTR_WIDTH-1:0] q_cnt;
   logic [1:0]           q_idx;
   logic [3:0]           bit_cnt;
   logic [7:0]           tx_shift;
   logic [7:0]           rx_shift;
   logic                 nack_r;
   logic                 bus_held;

   logic                 stretch;
   logic                 cmd_legal;
   logic                 cmd_nop;
   logic                 first_b;
   logic                 is_bit_op;
   logic [1:0]           last_q;
   logic                 seq_end;
   logic [1:0]           nxt_q_idx;
   logic [3:0]           nxt_bit_cnt;
   logic [7:0]           nxt_shift;
   logic                 nxt_b;
   logic [1:0]           nxt_pins;

   // Pin pair {sda, scl} for quarter q of a command. b is the data bit of a WRITE or READ bit slot.
   function automatic logic [1:0] quarter_pins(input logic [2:0] c, input logic [1:0] q,
                                               input logic b);
      logic [1:0] p;
      p = 2'b11;
      case (c)
         CMD_START:
            case (q)
               2'd0:    p = 2'b11;
               2'd1:    p = 2'b01;
               default: p = 2'b00;
            endcase
         CMD_RESTART:
            case (q)
               2'd0:    p = 2'b10;
               2'd1:    p = 2'b11;
               2'd2:    p = 2'b01;
               default: p = 2'b00;
            endcase
         CMD_STOP:
            case (q)
               2'd0:    p = 2'b00;
               2'd1:    p = 2'b01;
               default: p = 2'b11;
            endcase
         default:
            case (q)
               2'd0:    p = {b, 1'b0};
               2'd3:    p = {b, 1'b0};
               default: p = {b, 1'b1};
            endcase
      endcase
      return p;
   endfunction

`ifdef I2C_CLOCK_STRETCH_EN
   // A slave holding SCL low while the engine releases it freezes the quarter at its start
   assign stretch = scl_out && !scl_in;
`else
   logic unused_scl_in;
   assign unused_scl_in = scl_in;
   assign stretch       = 1'b0;
`endif

   // Decide whether the offered command is legal for the current bus ownership
   always_comb begin
      cmd_legal = 1'b0;
      cmd_nop   = 1'b0;
      case (cmd)
         CMD_START:                                  cmd_legal = !bus_held;
         CMD_WRITE, CMD_READ, CMD_STOP, CMD_RESTART: cmd_legal = bus_held;
         default:                                    cmd_nop   = 1'b1;
      endcase
      first_b = (cmd == CMD_WRITE) ? data_in[7] : 1'b1;
   end

   // Work out where the running sequence goes when the current quarter ends
   always_comb begin
      is_bit_op   = (op == CMD_WRITE) || (op == CMD_READ);
      last_q      = ((op == CMD_START) || (op == CMD_STOP)) ? 2'd2 : 2'd3;
      seq_end     = (q_idx == last_q) && (!is_bit_op || (bit_cnt == 4'd8));
      nxt_q_idx   = q_idx + 2'd1;
      nxt_bit_cnt = (is_bit_op && (q_idx == 2'd3)) ? bit_cnt + 4'd1 : bit_cnt;
      nxt_shift   = ((op == CMD_WRITE) && (q_idx == 2'd3)) ? {tx_shift[6:0], 1'b1} : tx_shift;
      if (op == CMD_WRITE) begin
         nxt_b = nxt_shift[7];
      end else begin
         nxt_b = (nxt_bit_cnt == 4'd8) ? nack_r : 1'b1;
      end
      nxt_pins = quarter_pins(op, nxt_q_idx, nxt_b);
   end

   // Engine FSM: accept a command, step the quarters, sample SDA, then return to ready
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state     <= ENG_READY;
         op        <= 3'd0;
         q_cnt     <= '0;
         q_idx     <= 2'd0;
         bit_cnt   <= 4'd0;
         tx_shift  <= 8'd0;
         rx_shift  <= 8'd0;
         nack_r    <= 1'b0;
         bus_held  <= 1'b0;
         sda_out   <= 1'b1;
         scl_out   <= 1'b1;
         ready_out <= 1'b1;
         data_out  <= 8'd0;
         valid_out <= 1'b0;
         ack_out   <= 1'b0;
         err_out   <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         err_out   <= 1'b0;
         case (state)
            ENG_READY: begin
               if (write && ready_out) begin
                  ready_out <= 1'b0;
                  op        <= cmd;
                  nack_r    <= nack;
                  tx_shift  <= data_in;
                  q_cnt     <= '0;
                  q_idx     <= 2'd0;
                  bit_cnt   <= 4'd0;
                  if (cmd_legal) begin
                     state              <= ENG_RUN;
                     {sda_out, scl_out} <= quarter_pins(cmd, 2'd0, first_b);
                  end else begin
                     state   <= ENG_NOBUS;
                     err_out <= !cmd_nop;
                  end
               end
            end
            ENG_RUN: begin
               if (stretch) begin
                  q_cnt <= '0;
               end else if (q_cnt != Q_LAST) begin
                  q_cnt <= q_cnt + 1'b1;
               end else begin
                  q_cnt <= '0;
                  if (is_bit_op && (q_idx == 2'd2)) begin
                     if ((op == CMD_READ) && (bit_cnt != 4'd8)) begin
                        rx_shift <= {rx_shift[6:0], sda_in};
                     end
                     if ((op == CMD_WRITE) && (bit_cnt == 4'd8)) begin
                        ack_out <= sda_in;
                     end
                  end
                  if (seq_end) begin
                     state    <= ENG_DONE;
                     bus_held <= (op != CMD_STOP);
                  end else begin
                     q_idx              <= nxt_q_idx;
                     bit_cnt            <= nxt_bit_cnt;
                     tx_shift           <= nxt_shift;
                     {sda_out, scl_out} <= nxt_pins;
                  end
               end
            end
            ENG_DONE: begin
               state     <= ENG_READY;
               ready_out <= 1'b1;
               if (op == CMD_READ) begin
                  data_out  <= rx_shift;
                  valid_out <= 1'b1;
               end
            end
            ENG_NOBUS: begin
               state     <= ENG_READY;
               ready_out <= 1'b1;
            end
            default: begin
               state     <= ENG_READY;
               ready_out <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_engine.sv
// tb_i2c_master_engine: directed bench for i2c_master_engine with CLK_DIV=4.
// A wired-AND slave model drives SDA and can stretch SCL. Every command is
// traced one cycle at a time from the accept edge, and the trace is checked
// against hand-computed quarter timings.
module tb_i2c_master_engine;

   localparam int CLK_DIV = 4;

   localparam logic [2:0] CMD_NOP     = 3'd0;
   localparam logic [2:0] CMD_START   = 3'd1;
   localparam logic [2:0] CMD_WRITE   = 3'd2;
   localparam logic [2:0] CMD_READ    = 3'd3;
   localparam logic [2:0] CMD_STOP    = 3'd4;
   localparam logic [2:0] CMD_RESTART = 3'd5;

`ifdef I2C_CLOCK_STRETCH_EN
   localparam int STRETCH_BUSY = 155;
`else
   localparam int STRETCH_BUSY = 145;
`endif

   logic       clk_in = 1'b0;
   logic       reset_in;
   logic       write;
   logic [2:0] cmd;
   logic [7:0] data_in;
   logic       nack;
   logic       sda_in;
   logic       scl_in;
   logic       ready_out;
   logic       sda_out;
   logic       scl_out;
   logic [7:0] data_out;
   logic       valid_out;
   logic       ack_out;
   logic       err_out;

   logic       slave_sda;
   logic       stretch_force;
   logic       read_mode;
   logic       ack_level;
   logic [7:0] read_byte;
   int         stretch_at;

   int         checks   = 0;
   int         failures = 0;

   logic [1:0] trace [0:511];
   int         busy;
   int         err_cnt;
   int         valid_cnt;
   logic       post_valid;
   logic [7:0] ready_data;

   assign sda_in = sda_out & slave_sda;
   assign scl_in = scl_out & ~stretch_force;

   i2c_master_engine #(
      .CLK_DIV   (CLK_DIV),
      .CTR_WIDTH (16)
   ) dut (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .write     (write),
      .cmd       (cmd),
      .data_in   (data_in),
      .nack      (nack),
      .sda_in    (sda_in),
      .scl_in    (scl_in),
      .ready_out (ready_out),
      .sda_out   (sda_out),
      .scl_out   (scl_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ack_out   (ack_out),
      .err_out   (err_out)
   );

   // Free-running 10-time-unit system clock
   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Slave SDA level for trace cycle n: the read byte MSB first, or a constant ACK level
   function automatic logic slaveLevel(input int n);
      if (read_mode) begin
         if ((n / 16) < 8) return read_byte[7 - (n / 16)];
         return 1'b1;
      end
      return ack_level;
   endfunction

   // Issue one command, then trace the bus once per cycle until ready_out returns
   task automatic applyStimulus(input logic [2:0] c, input logic [7:0] d, input logic nk);
      int n;
      busy       = -1;
      err_cnt    = 0;
      valid_cnt  = 0;
      ready_data = 8'h00;
      cmd        = c;
      data_in    = d;
      nack       = nk;
      write      = 1'b1;
      @(posedge clk_in);
      #1;
      write = 1'b0;
      cmd   = CMD_NOP;
      n     = 0;
      while (busy < 0 && n < 400) begin
         slave_sda     = slaveLevel(n);
         stretch_force = (stretch_at >= 0) && (n >= stretch_at) && (n < stretch_at + 10);
         @(negedge clk_in);
         trace[n] = {sda_out, scl_out};
         if (err_out) err_cnt++;
         if (valid_out) valid_cnt++;
         if (ready_out) begin
            busy       = n;
            ready_data = data_out;
         end
         @(posedge clk_in);
         #1;
         n++;
      end
      slave_sda     = 1'b1;
      stretch_force = 1'b0;
      @(negedge clk_in);
      post_valid = valid_out;
   endtask

   // Check SDA of all nine bit slots: the SCL-low first quarter and the SCL-high second quarter
   task automatic checkBits(input string tag, input logic [8:0] bits);
      for (int k = 0; k < 9; k++) begin
         checkOutput($sformatf("%s_lo%0d", tag, k), trace[16 * k], {bits[8 - k], 1'b0});
         checkOutput($sformatf("%s_hi%0d", tag, k), trace[16 * k + 4], {bits[8 - k], 1'b1});
      end
   endtask

   initial begin
      reset_in      = 1'b1;
      write         = 1'b0;
      cmd           = CMD_NOP;
      data_in       = 8'h00;
      nack          = 1'b0;
      slave_sda     = 1'b1;
      stretch_force = 1'b0;
      read_mode     = 1'b0;
      ack_level     = 1'b0;
      read_byte     = 8'h00;
      stretch_at    = -1;

      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      checkOutput("rst_pins", {sda_out, scl_out}, 2'b11);
      checkOutput("rst_ready", ready_out, 1'b1);
      checkOutput("rst_data", data_out, 8'h00);
      checkOutput("rst_flags", {valid_out, ack_out, err_out}, 3'b000);
      reset_in = 1'b0;
      @(negedge clk_in);

      $display("[TB] NOP and illegal commands on idle bus");
      applyStimulus(CMD_NOP, 8'h00, 1'b0);
      checkOutput("nop0_busy", busy, 1);
      checkOutput("nop0_err", err_cnt, 0);
      applyStimulus(3'd7, 8'h00, 1'b0);
      checkOutput("nop7_err", err_cnt, 0);
      applyStimulus(CMD_STOP, 8'h00, 1'b0);
      checkOutput("stop_idle_busy", busy, 1);
      checkOutput("stop_idle_err", err_cnt, 1);
      checkOutput("stop_idle_pins", trace[0], 2'b11);

      $display("[TB] START");
      applyStimulus(CMD_START, 8'h00, 1'b0);
      checkOutput("start_busy", busy, 13);
      checkOutput("start_q0", trace[3], 2'b11);
      checkOutput("start_q1a", trace[4], 2'b01);
      checkOutput("start_q1b", trace[7], 2'b01);
      checkOutput("start_q2", trace[8], 2'b00);
      checkOutput("start_end", trace[13], 2'b00);
      checkOutput("start_err", err_cnt, 0);
      applyStimulus(CMD_START, 8'h00, 1'b0);
      checkOutput("start_held_err", err_cnt, 1);
      checkOutput("start_held_pins", trace[0], 2'b00);

      $display("[TB] WRITE 0xA5 with ACK");
      ack_level = 1'b0;
      applyStimulus(CMD_WRITE, 8'hA5, 1'b0);
      checkOutput("wr_a5_busy", busy, 145);
      checkBits("wr_a5", 9'b101001011);
      checkOutput("wr_a5_ack", ack_out, 1'b0);
      checkOutput("wr_a5_valid", valid_cnt, 0);

      $display("[TB] WRITE 0x5A with NACK");
      ack_level = 1'b1;
      applyStimulus(CMD_WRITE, 8'h5A, 1'b0);
      checkOutput("wr_5a_busy", busy, 145);
      checkBits("wr_5a", 9'b010110101);
      checkOutput("wr_5a_ack", ack_out, 1'b1);

      $display("[TB] READ 0x3C with NACK, READ 0xC3 with ACK");
      read_mode = 1'b1;
      read_byte = 8'h3C;
      applyStimulus(CMD_READ, 8'h00, 1'b1);
      checkOutput("rd_3c_busy", busy, 145);
      checkOutput("rd_3c_data", ready_data, 8'h3C);
      checkOutput("rd_3c_vcnt", valid_cnt, 1);
      checkOutput("rd_3c_vpost", post_valid, 1'b0);
      checkOutput("rd_3c_b9lo", trace[128], 2'b10);
      checkOutput("rd_3c_b9hi", trace[132], 2'b11);
      checkOutput("rd_3c_b0hi", trace[4], 2'b11);
      read_byte = 8'hC3;
      applyStimulus(CMD_READ, 8'h00, 1'b0);
      checkOutput("rd_c3_data", ready_data, 8'hC3);
      checkOutput("rd_c3_dout", data_out, 8'hC3);
      checkOutput("rd_c3_b9hi", trace[132], 2'b01);
      checkOutput("rd_c3_ack", ack_out, 1'b1);
      read_mode = 1'b0;

      $display("[TB] RESTART then STOP");
      applyStimulus(CMD_RESTART, 8'h00, 1'b0);
      checkOutput("rs_busy", busy, 17);
      checkOutput("rs_q0", trace[0], 2'b10);
      checkOutput("rs_q1", trace[4], 2'b11);
      checkOutput("rs_q2", trace[8], 2'b01);
      checkOutput("rs_q3", trace[12], 2'b00);
      applyStimulus(CMD_STOP, 8'h00, 1'b0);
      checkOutput("sp_busy", busy, 13);
      checkOutput("sp_q0", trace[0], 2'b00);
      checkOutput("sp_q1", trace[4], 2'b01);
      checkOutput("sp_q2", trace[8], 2'b11);
      checkOutput("sp_end", trace[13], 2'b11);
      applyStimulus(CMD_WRITE, 8'h00, 1'b0);
      checkOutput("wr_idle_err", err_cnt, 1);
      checkOutput("wr_idle_busy", busy, 1);
      checkOutput("wr_idle_pins", {trace[0], trace[1]}, 4'b1111);

      $display("[TB] WRITE with SCL stretch in bit 3");
      applyStimulus(CMD_START, 8'h00, 1'b0);
      ack_level  = 1'b0;
      stretch_at = 52;
      applyStimulus(CMD_WRITE, 8'h96, 1'b0);
      stretch_at = -1;
      checkOutput("stretch_busy", busy, STRETCH_BUSY);
      checkOutput("stretch_ack", ack_out, 1'b0);

      $display("[TB] Reset in the middle of a WRITE");
      cmd     = CMD_WRITE;
      data_in = 8'h00;
      write   = 1'b1;
      @(posedge clk_in);
      #1;
      write = 1'b0;
      repeat (17) @(posedge clk_in);
      #2;
      checkOutput("mid_pins", {sda_out, scl_out}, 2'b00);
      checkOutput("mid_ready", ready_out, 1'b0);
      reset_in = 1'b1;
      #1;
      checkOutput("mid_rst_pins", {sda_out, scl_out}, 2'b11);
      checkOutput("mid_rst_ready", ready_out, 1'b1);
      checkOutput("mid_rst_err", err_out, 1'b0);
      repeat (2) @(negedge clk_in);
      reset_in = 1'b0;
      @(negedge clk_in);
      applyStimulus(CMD_START, 8'h00, 1'b0);
      checkOutput("post_rst_start", busy, 13);
      checkOutput("post_rst_err", err_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
